// File: rtl/fila_pkg.sv
// Shared types and sizing for the fila byte-transfer path.
package fila_pkg;
    localparam int BYTE_W = 8;
    localparam int DEPTH  = 8;

    typedef enum logic [2:0] {
        IDLE,
        PUSH,
        ACK,
        RELEASE,
        FULL_WAIT
    } xfer_state_t;
endpackage

// File: rtl/fila_transfer_ctrl_tick_gen.sv
// Free-running clock-enable divider: one-cycle tick every DIV cycles.
// Latency: first tick in the DIV-th cycle after reset release.
// Backpressure: none, free-running.
module tick_gen #(
    parameter int DIV = 10
) (
    input  logic clock1MHz,
    input  logic reset,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_count;

    always_ff @(posedge clock1MHz) begin
        if (reset) begin
            r_count <= '0;
        end else if (r_count == CW'(DIV - 1)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

    assign tick = (r_count == CW'(DIV - 1));
endmodule

// File: rtl/fila_transfer_ctrl.sv
// Deserializer-to-fila byte sequencer with clock enables and paced dequeue; FILA_DROP_ON_FULL_EN drops bytes when full.
// Latency: data_ready -> enqueue_fila 1 cycle, enqueue_fila -> ack_serial 1 cycle; dequeue_fila combinational on tick_10k.
// Backpressure: withholds ack_serial (stalling the deserializer) while the fila is full.
module fila_transfer_ctrl #(
    parameter int DEPTH      = fila_pkg::DEPTH,
    parameter int DIV_FAST   = 10,
    parameter int DIV_SLOW   = 100,
    parameter int ACK_CYCLES = 10
) (
    input  logic       clock1MHz,
    input  logic       reset,
    input  logic       data_ready,
    input  logic [7:0] data_parallel,
    input  logic [7:0] fila_len,
    input  logic       dequeue_req,
    output logic       ack_serial,
    output logic       enqueue_fila,
    output logic [7:0] enqueue_data,
    output logic       dequeue_fila,
    output logic       tick_100k,
    output logic       tick_10k,
    output logic       status_busy
`ifdef FILA_DROP_ON_FULL_EN
    ,
    output logic [7:0] drop_count
`endif
);
    import fila_pkg::*;

    localparam int ACK_W = $clog2(ACK_CYCLES + 1);

    xfer_state_t             r_state;
    logic [BYTE_W-1:0]       r_byte;
    logic [ACK_W-1:0]        r_ack_cnt;
    logic                    w_room;

    assign w_room = (fila_len < 8'(DEPTH));

    tick_gen #(.DIV(DIV_FAST)) u_tick_fast (
        .clock1MHz (clock1MHz),
        .reset     (reset),
        .tick      (tick_100k)
    );

    tick_gen #(.DIV(DIV_SLOW)) u_tick_slow (
        .clock1MHz (clock1MHz),
        .reset     (reset),
        .tick      (tick_10k)
    );

    // One pop per slow period; fila_len is the fila's own registered count.
    assign dequeue_fila = tick_10k & dequeue_req & (fila_len != 8'd0);

`ifdef FILA_DROP_ON_FULL_EN
    logic [7:0] r_drop;
    assign drop_count = r_drop;
`endif

    always_ff @(posedge clock1MHz) begin
        if (reset) begin
            r_state      <= IDLE;
            r_byte       <= '0;
            r_ack_cnt    <= '0;
            ack_serial   <= 1'b0;
            enqueue_fila <= 1'b0;
            enqueue_data <= '0;
            status_busy  <= 1'b0;
`ifdef FILA_DROP_ON_FULL_EN
            r_drop       <= '0;
`endif
        end else begin
            enqueue_fila <= 1'b0;
            enqueue_data <= '0;
            case (r_state)
                IDLE: begin
                    if (data_ready) begin
                        r_byte      <= data_parallel;
                        status_busy <= 1'b1;
                        if (w_room) begin
                            r_state      <= PUSH;
                            enqueue_fila <= 1'b1;
                            enqueue_data <= data_parallel;
                        end else begin
`ifdef FILA_DROP_ON_FULL_EN
                            r_state    <= ACK;
                            ack_serial <= 1'b1;
                            r_ack_cnt  <= '0;
                            if (r_drop != 8'hFF) begin
                                r_drop <= r_drop + 8'd1;
                            end
`else
                            r_state <= FULL_WAIT;
`endif
                        end
                    end
                end
                PUSH: begin
                    r_state    <= ACK;
                    ack_serial <= 1'b1;
                    r_ack_cnt  <= '0;
                end
                ACK: begin
                    if (r_ack_cnt == ACK_W'(ACK_CYCLES - 1)) begin
                        r_state    <= RELEASE;
                        ack_serial <= 1'b0;
                    end else begin
                        r_ack_cnt <= r_ack_cnt + ACK_W'(1);
                    end
                end
                RELEASE: begin
                    // Wait for the deserializer to drop data_ready so one byte is never taken twice.
                    if (!data_ready) begin
                        r_state     <= IDLE;
                        status_busy <= 1'b0;
                    end
                end
                FULL_WAIT: begin
                    if (w_room) begin
                        r_state      <= PUSH;
                        enqueue_fila <= 1'b1;
                        enqueue_data <= r_byte;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    status_busy <= 1'b0;
                    ack_serial  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fila_transfer_ctrl.sv
// Self-checking bench for fila_transfer_ctrl: directed table, FULL_WAIT/drop, dequeue pacing, reset, random traffic.
module tb_fila_transfer_ctrl;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       data_ready = 1'b0;
    logic [7:0] data_parallel = 8'h00;
    logic [7:0] fila_len = 8'h00;
    logic       dequeue_req = 1'b0;
    logic       ack_serial, enqueue_fila, dequeue_fila, tick_100k, tick_10k, status_busy;
    logic [7:0] enqueue_data;
`ifdef FILA_DROP_ON_FULL_EN
    logic [7:0] drop_count;
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    int n_chk = 0;
    int n_fail = 0;
    int since_rel = 0;
    bit fila_auto = 1'b0;

    always #5 clk = ~clk;

    fila_transfer_ctrl dut (
        .clock1MHz     (clk),
        .reset         (reset),
        .data_ready    (data_ready),
        .data_parallel (data_parallel),
        .fila_len      (fila_len),
        .dequeue_req   (dequeue_req),
        .ack_serial    (ack_serial),
        .enqueue_fila  (enqueue_fila),
        .enqueue_data  (enqueue_data),
        .dequeue_fila  (dequeue_fila),
        .tick_100k     (tick_100k),
        .tick_10k      (tick_10k),
        .status_busy   (status_busy)
`ifdef FILA_DROP_ON_FULL_EN
        ,
        .drop_count    (drop_count)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock: fila occupancy model follows the strobes, ticks/pops checked against cycles since release.
    task automatic step();
        logic e, d;
        e = enqueue_fila;
        d = dequeue_fila;
        @(posedge clk);
        if (reset) since_rel = 0;
        else since_rel++;
        #1;
        if (fila_auto) begin
            if (e) chk("no_push_full", 32'(fila_len < 8'(DEPTH)), 1);
            fila_len = fila_len + 8'(e) - 8'(d);
        end
        chk("tick_100k", 32'(tick_100k), 32'(since_rel % 10 == 9));
        chk("tick_10k", 32'(tick_10k), 32'(since_rel % 100 == 99));
        chk("deq_rule", 32'(dequeue_fila),
            32'((since_rel % 100 == 99) && dequeue_req && (fila_len != 0)));
    endtask

    // Deserializer handshake for one byte: raise, wait for ack, hold briefly, release.
    task automatic send_byte(input logic [7:0] b, input bit exp_push, input bit chk_lat);
        int t, t_enq, t_ack, n_enq, n_ack, n_late;
        bit ok_data;
        data_parallel = b;
        data_ready = 1'b1;
        t = 0; t_enq = -1; t_ack = -1; n_enq = 0; n_ack = 0; n_late = 0; ok_data = 1'b1;
        while (t < 400 && !(t_ack >= 0 && !ack_serial)) begin
            step();
            t++;
            if (enqueue_fila) begin
                n_enq++;
                if (t_enq < 0) t_enq = t;
                if (enqueue_data !== b) ok_data = 1'b0;
            end
            if (ack_serial) begin
                n_ack++;
                if (t_ack < 0) t_ack = t;
            end
        end
        chk("handshake_timeout", 32'(t < 400), 1);
        chk("enq_count", n_enq, 32'(exp_push));
        chk("enq_data", 32'(ok_data), 1);
        chk("ack_len", n_ack, 10);
        if (chk_lat) begin
            if (exp_push) chk("lat_enq", t_enq, 1);
            chk("lat_ack", t_ack, exp_push ? 2 : 1);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            if (enqueue_fila || ack_serial) n_late++;
        end
        chk("release_hold_idle", n_late, 0);
        chk("release_busy", 32'(status_busy), 1);
        data_ready = 1'b0;
        step();
        chk("back_to_idle", 32'(status_busy), 0);
    endtask

    typedef struct {
        logic [7:0] din;
        logic [7:0] flen;
    } vec_t;

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        int   n100, n10, cnt, nbad;
        vecs[0] = '{8'hA5, 8'd0};
        vecs[1] = '{8'h3C, 8'd5};
        vecs[2] = '{8'hFF, 8'd7};
        vecs[3] = '{8'h01, 8'd2};

        // Reset and clock enables
        for (int i = 0; i < 100; i++) step();
        reset = 1'b0;
        chk("rst_ack", 32'(ack_serial), 0);
        chk("rst_enq", 32'(enqueue_fila), 0);
        chk("rst_enq_data", 32'(enqueue_data), 0);
        chk("rst_deq", 32'(dequeue_fila), 0);
        chk("rst_busy", 32'(status_busy), 0);
        chk("rst_ticks", {tick_100k, tick_10k}, 0);
`ifdef FILA_DROP_ON_FULL_EN
        chk("rst_drop", 32'(drop_count), 0);
`endif
        n100 = 0; n10 = 0;
        for (int i = 0; i < 250; i++) begin
            step();
            if (tick_100k) n100++;
            if (tick_10k) n10++;
        end
        chk("tick100_count", n100, 25);
        chk("tick10_count", n10, 2);

        // Table of single transfers with room in the fila
        foreach (vecs[i]) begin
            fila_len = vecs[i].flen;
            send_byte(vecs[i].din, 1'b1, 1'b1);
        end

`ifndef FILA_DROP_ON_FULL_EN
        // Fill to DEPTH, then a 9th byte must stall in FULL_WAIT
        fila_len = 0;
        fila_auto = 1'b1;
        for (int i = 0; i < DEPTH; i++) send_byte(8'h10 + 8'(i), 1'b1, 1'b1);
        chk("fill_len", 32'(fila_len), DEPTH);
        fila_auto = 1'b0;
        data_parallel = 8'hAA;
        data_ready = 1'b1;
        step();
        chk("fw_busy", 32'(status_busy), 1);
        chk("fw_enq0", 32'(enqueue_fila), 0);
        nbad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (ack_serial || enqueue_fila) nbad++;
        end
        chk("fw_stalled", nbad, 0);
        data_parallel = 8'h55;
        fila_len = 8'd7;
        step();
        chk("fw_push", 32'(enqueue_fila), 1);
        chk("fw_push_data", 32'(enqueue_data), 32'h AA);
        step();
        cnt = 0;
        while (ack_serial && cnt < 50) begin
            cnt++;
            step();
        end
        chk("fw_ack_len", cnt, 10);
        data_ready = 1'b0;
        step();
        chk("fw_idle", 32'(status_busy), 0);
`else
        // Full fila in drop mode: every byte acked, none pushed, counter saturates
        fila_len = 8'd8;
        send_byte(8'h5A, 1'b0, 1'b1);
        chk("drop_first", 32'(drop_count), 1);
        for (int i = 1; i < 300; i++) send_byte(8'($urandom), 1'b0, 1'b0);
        chk("drop_sat", 32'(drop_count), 255);
`endif

        // Paced dequeue of three bytes
        fila_len = 8'd3;
        fila_auto = 1'b1;
        dequeue_req = 1'b1;
        cnt = 0;
        for (int i = 0; i < 450; i++) begin
            step();
            if (dequeue_fila) begin
                cnt++;
                chk("deq_on_tick", 32'(tick_10k), 1);
            end
        end
        chk("deq_count", cnt, 3);
        chk("deq_len_zero", 32'(fila_len), 0);
        dequeue_req = 1'b0;

        // Random traffic against the fila occupancy model
        for (int n = 0; n < 60; n++) begin
            int gap;
            logic ep;
            gap = $urandom_range(0, 20);
            dequeue_req = DROP ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
            for (int g = 0; g < gap; g++) step();
            if (!DROP && fila_len == 8'(DEPTH)) dequeue_req = 1'b1;
            ep = DROP ? (fila_len < 8'(DEPTH)) : 1'b1;
            send_byte(8'($urandom), ep, 1'b0);
            chk("rand_len_bound", 32'(fila_len <= 8'(DEPTH)), 1);
        end
        dequeue_req = 1'b0;
        fila_auto = 1'b0;

        // Reset in the middle of ACK
        fila_len = 8'd0;
        data_parallel = 8'h77;
        data_ready = 1'b1;
        step();
        chk("mid_enq", 32'(enqueue_fila), 1);
        step();
        chk("mid_ack", 32'(ack_serial), 1);
        step();
        step();
        reset = 1'b1;
        step();
        chk("mid_rst_ack", 32'(ack_serial), 0);
        chk("mid_rst_busy", 32'(status_busy), 0);
        chk("mid_rst_enq", 32'(enqueue_fila), 0);
        step();
        reset = 1'b0;
        data_ready = 1'b0;
        nbad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (enqueue_fila || ack_serial || status_busy) nbad++;
        end
        chk("post_rst_quiet", nbad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
